uart_tx_arbiter: RTL
====================

Name: uart_tx_arbiter

Overview:
Shares one 8N1 UART transmitter (CLKS_PER_BIT-timed, single-byte i_TX_DV/o_TX_Done handshake) between N_REQ byte-stream requesters, such as the order-ack, market-data echo and debug sources.
Arbitration is round-robin at frame granularity: once granted, a requester keeps the transmitter until it sends a byte flagged last.
The block sequences each byte into the transmitter, waits for its done pulse, and releases the grant on frame end or on an inter-byte timeout.
It sits between the message formatters and the UART transmitter instance.

Parameters:
N_REQ, 4, number of requesters (2..8)
TIMEOUT_CLKS, 4096, max clocks a granted requester may leave valid low between bytes; 0 disables the timeout

Ports:
i_Clock  input  1  system clock
i_Rst_L  input  1  asynchronous active-low reset
i_Req_Valid  input  N_REQ  per-requester byte valid
i_Req_Byte  input  8*N_REQ  per-requester byte; requester k occupies bits [8k+7:8k]
i_Req_Last  input  N_REQ  byte is the final byte of its frame
o_Req_Ready  output  N_REQ  per-requester ready; at most one bit high
o_Grant  output  N_REQ  one-hot owner of the transmitter; all zero when idle
o_TX_DV  output  1  one-cycle start pulse to the transmitter
o_TX_Byte  output  8  byte to the transmitter; held stable until the next load
i_TX_Done  input  1  transmitter done pulse, one cycle, at end of stop bit
o_Frame_Abort  output  1  one-cycle pulse when a grant is revoked by timeout
o_Busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (async assert, sync release): state=IDLE; o_Grant=0; o_Req_Ready=0; o_TX_DV=0; o_TX_Byte=8'h00; o_Frame_Abort=0; o_Busy=0; priority pointer=0 (requester 0 is checked first); timer=0.
- States:
  - IDLE -> GRANTED when any i_Req_Valid bit is high.
  - GRANTED -> WAIT_DONE on handshake.
  - GRANTED -> IDLE on timeout.
  - WAIT_DONE -> GRANTED on i_TX_Done with the last flag clear.
  - WAIT_DONE -> IDLE on i_TX_Done with the last flag set.
- Arbitration in IDLE:
  - Scan from the pointer upward, modulo N_REQ; the first valid requester wins.
  - o_Grant is registered and becomes valid the cycle after the request is seen.
  - The pointer updates to winner+1 (mod N_REQ) only when the frame completes or aborts.
- GRANTED:
  - o_Req_Ready[g] = 1, combinational from state and grant; all other ready bits are 0.
  - Handshake = valid[g] & ready[g].
  - On handshake, register: o_TX_Byte <= byte[g]; o_TX_DV <= 1 for exactly one cycle; last flag <= last[g].
  - Earliest o_TX_DV is 2 cycles after valid first rises from IDLE (grant cycle, then handshake cycle).
- WAIT_DONE:
  - Ready is low; valid and byte inputs are ignored.
  - i_TX_Done returns to GRANTED; the next byte's DV is issued no earlier than 2 cycles after Done, so the transmitter has reached its idle state.
  - A Done pulse arriving in any state other than WAIT_DONE is ignored.
- Timeout:
  - The timer counts in GRANTED while valid[g]=0 and clears on handshake.
  - When the timer reaches TIMEOUT_CLKS-1: pulse o_Frame_Abort, clear o_Grant, advance the pointer, go to IDLE.
  - If valid rises on the same cycle the timeout fires, the handshake wins and no abort occurs.
- Requester rules:
  - Requesters must hold byte and last stable while valid and not ready.
  - Dropping valid mid-frame is legal and only runs the timer.
- Requests from other requesters during a frame are held off; the frame is never interleaved.
- A single-byte frame is a byte with last=1 on the first handshake.
- o_Busy = (state != IDLE).
- Reset mid-frame clears everything immediately; the transmitter is reset by the same i_Rst_L.
- Widths:
  - Timer is $clog2(TIMEOUT_CLKS+1) bits.
  - Pointer is $clog2(N_REQ) bits and wraps explicitly at N_REQ-1 -> 0, since N_REQ need not be a power of 2.

Decomposition:
- Shared package holds the state encoding localparams (IDLE=2'b00, GRANTED=2'b01, WAIT_DONE=2'b10) and the default TIMEOUT_CLKS.
- One sub-module is natural: rr_pick, a combinational rotate-priority encoder taking (req, ptr) and returning a one-hot winner, reusable by later arbiters.

Test Plan:
- Single requester 1, frame 8'h41,8'h42 (last) -> two DV pulses with o_TX_Byte 41 then 42; second DV no earlier than 2 clocks after first Done; o_Grant=4'b0010 throughout, then 0.
- Requesters 0 and 2 valid simultaneously from reset -> 0 is served first, then 2; with 0 re-requesting, order is 0,2,0 (round-robin via the pointer).
- Requester 3 sends 3 bytes while requester 1 is valid -> no ready to 1 until 3's last-byte Done; no interleaving.
- Requester 0 sends one byte with last=0, then holds valid low with TIMEOUT_CLKS=16 -> o_Frame_Abort pulses exactly 16 clocks after entering GRANTED; grant clears; the next requester is served.
- i_Rst_L asserted during WAIT_DONE -> all outputs return to reset values asynchronously; after release, requester 0 has priority.
- Spurious i_TX_Done in IDLE and GRANTED -> no state change, no DV.

Source files
------------

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM state encoding and
// default timeout.
package uart_tx_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_GRANTED   = 2'b01,
        ST_WAIT_DONE = 2'b10
    } state_e;

    localparam int DEFAULT_TIMEOUT_CLKS = 4096;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Rotating-priority pick: scans the request vector upward from i_ptr
// (wrapping at N-1 -> 0) and returns the first set bit as one-hot plus index.
module uart_tx_arbiter_rr_pick #(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_win,
    output logic [PW-1:0] o_win_idx
);

    logic          w_found;
    logic          w_hit;
    logic [PW-1:0] w_idx;
    int            w_sum;

    // Walk the requesters in priority order; only the first hit is kept.
    always_comb begin
        o_win     = '0;
        o_win_idx = '0;
        w_found   = 1'b0;
        w_hit     = 1'b0;
        w_idx     = '0;
        w_sum     = 0;
        for (int i = 0; i < N; i++) begin
            w_sum = int'(i_ptr) + i;
            w_sum = (w_sum >= N) ? (w_sum - N) : w_sum;
            w_idx = PW'(w_sum);
            w_hit = i_req[w_idx] & ~w_found;
            o_win[w_idx] = o_win[w_idx] | w_hit;
            o_win_idx = o_win_idx | ({PW{w_hit}} & w_idx);
            w_found = w_found | w_hit;
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between N_REQ byte-stream requesters with
// frame-granular round-robin arbitration and an inter-byte timeout.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int N_REQ        = 4,
    parameter int TIMEOUT_CLKS = DEFAULT_TIMEOUT_CLKS
) (
    input  logic                 i_Clock,
    input  logic                 i_Rst_L,
    input  logic [N_REQ-1:0]     i_Req_Valid,
    input  logic [8*N_REQ-1:0]   i_Req_Byte,
    input  logic [N_REQ-1:0]     i_Req_Last,
    output logic [N_REQ-1:0]     o_Req_Ready,
    output logic [N_REQ-1:0]     o_Grant,
    output logic                 o_TX_DV,
    output logic [7:0]           o_TX_Byte,
    input  logic                 i_TX_Done,
    output logic                 o_Frame_Abort,
    output logic                 o_Busy
);

    localparam int PW = $clog2(N_REQ);
    localparam int TW = (TIMEOUT_CLKS > 0) ? $clog2(TIMEOUT_CLKS + 1) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT_CLKS > 0) ? (TIMEOUT_CLKS - 1) : 0);
    localparam logic [PW-1:0] PTR_MAX  = PW'(N_REQ - 1);

    state_e             r_state;
    logic [N_REQ-1:0]   r_grant;
    logic [PW-1:0]      r_idx;
    logic [PW-1:0]      r_ptr;
    logic [TW-1:0]      r_timer;
    logic               r_last;
    logic               r_tx_dv;
    logic [7:0]         r_tx_byte;
    logic               r_abort;

    logic [N_REQ-1:0]   w_pick;
    logic [PW-1:0]      w_pick_idx;
    logic               w_any;
    logic [PW-1:0]      w_next_ptr;
    logic [7:0]         w_byte_g;
    logic               w_last_g;
    logic               w_valid_g;
    logic               w_sel;
    logic               w_tmo;

    uart_tx_arbiter_rr_pick #(
        .N  (N_REQ),
        .PW (PW)
    ) u_pick (
        .i_req     (i_Req_Valid),
        .i_ptr     (r_ptr),
        .o_win     (w_pick),
        .o_win_idx (w_pick_idx)
    );

    assign w_any      = |i_Req_Valid;
    assign w_next_ptr = (r_idx == PTR_MAX) ? '0 : (r_idx + PW'(1'b1));
    assign w_tmo      = (TIMEOUT_CLKS != 0) && (r_timer == TMO_LAST);

    // Select the granted requester's valid, byte and last flag.
    always_comb begin
        w_byte_g  = 8'h00;
        w_last_g  = 1'b0;
        w_valid_g = 1'b0;
        w_sel     = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            w_sel     = (r_idx == PW'(k));
            w_byte_g  = w_byte_g | ({8{w_sel}} & i_Req_Byte[8*k +: 8]);
            w_last_g  = w_last_g | (w_sel & i_Req_Last[k]);
            w_valid_g = w_valid_g | (w_sel & i_Req_Valid[k]);
        end
    end

    // Arbitration FSM: grant, byte sequencing, done wait and timeout.
    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_state   <= ST_IDLE;
            r_grant   <= '0;
            r_idx     <= '0;
            r_ptr     <= '0;
            r_timer   <= '0;
            r_last    <= 1'b0;
            r_tx_dv   <= 1'b0;
            r_tx_byte <= 8'h00;
            r_abort   <= 1'b0;
        end else begin
            r_tx_dv <= 1'b0;
            r_abort <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_timer <= '0;
                    if (w_any) begin
                        r_grant <= w_pick;
                        r_idx   <= w_pick_idx;
                        r_state <= ST_GRANTED;
                    end
                end
                ST_GRANTED: begin
                    // A byte offered on the timeout cycle still wins.
                    if (w_valid_g) begin
                        r_tx_byte <= w_byte_g;
                        r_tx_dv   <= 1'b1;
                        r_last    <= w_last_g;
                        r_timer   <= '0;
                        r_state   <= ST_WAIT_DONE;
                    end else if (w_tmo) begin
                        r_abort <= 1'b1;
                        r_grant <= '0;
                        r_ptr   <= w_next_ptr;
                        r_timer <= '0;
                        r_state <= ST_IDLE;
                    end else if (TIMEOUT_CLKS != 0) begin
                        r_timer <= r_timer + TW'(1'b1);
                    end
                end
                ST_WAIT_DONE: begin
                    if (i_TX_Done) begin
                        if (r_last) begin
                            r_grant <= '0;
                            r_ptr   <= w_next_ptr;
                            r_state <= ST_IDLE;
                        end else begin
                            r_state <= ST_GRANTED;
                        end
                    end
                end
                default: begin
                    r_grant <= '0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_Req_Ready   = (r_state == ST_GRANTED) ? r_grant : '0;
    assign o_Grant       = r_grant;
    assign o_TX_DV       = r_tx_dv;
    assign o_TX_Byte     = r_tx_byte;
    assign o_Frame_Abort = r_abort;
    assign o_Busy        = (r_state != ST_IDLE);

endmodule
